// File: rtl/fp2int.sv
// Sequential converter from the lab 8-bit float (s, e[2:0] bias 3, m[3:0], hidden 1)
// to an 8-bit two's-complement integer, truncating toward zero via an iterative shifter.
module fp2int (
   input  logic       clk,
   input  logic       clr,
   input  logic       start,
   input  logic [7:0] a,
   output logic [7:0] q,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [11:0] r;
   logic [2:0]  cnt;
   logic        sg;
   logic [7:0]  mag;

   // Integer part of 1.mmmm x 2^e lands in R[11:7] once all e shifts are done.
   assign mag = {3'b000, r[11:7]};

   // ---------------- controller ----------------
   // NOTE: every combinational output gets a default before the case, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (cnt == 3'd0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) state <= IDLE;
      else     state <= state_nxt;
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (clr) begin
         r   <= '0;
         cnt <= '0;
         sg  <= 1'b0;
         q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  r   <= {7'b0000000, 1'b1, a[3:0]};
                  cnt <= a[6:4];
                  sg  <= a[7];
               end
            end
            SHIFT: begin
               if (cnt != 3'd0) begin
                  r   <= r << 1;
                  cnt <= cnt - 3'd1;
               end else begin
                  // Negating a zero magnitude yields 8'h00, so there is no -0 result.
                  q <= sg ? (8'd0 - mag) : mag;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_fp2int.sv
// Self-checking bench for fp2int: directed corner cases plus random operands,
// compared against a real-arithmetic model of the float format.
module tb_fp2int;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = 8'h00;
   logic [7:0] q;
   logic       busy;
   logic       done;

   int n_vec  = 0;
   int n_fail = 0;

   fp2int dut (
      .clk   (clk),
      .clr   (clr),
      .start (start),
      .a     (a),
      .q     (q),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Value of the float computed directly, then truncated toward zero.
   function automatic logic [7:0] ref_q(input logic [7:0] op);
      real v;
      int  m;
      v = (1.0 + real'(op[3:0]) / 16.0) * (2.0 ** (real'(op[6:4]) - 3.0));
      m = int'($floor(v));
      return op[7] ? 8'(-m) : 8'(m);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Runs one conversion starting in the current (IDLE) cycle. If inj_cyc > 0, a
   // stray start with operand inj_a is driven during that cycle and must be ignored.
   task automatic convert(input logic [7:0] op, input int inj_cyc, input logic [7:0] inj_a);
      int         cyc;
      int         busy_cnt;
      int         early_q;
      logic [7:0] q_old;
      logic [7:0] exp_q;
      exp_q   = ref_q(op);
      q_old   = q;
      start   = 1'b1;
      a       = op;
      next_cycle();
      cyc      = 1;
      busy_cnt = 0;
      early_q  = 0;
      start    = 1'b0;
      a        = 8'($urandom);
      while (!done && cyc < 20) begin
         if (busy) busy_cnt++;
         if (q !== q_old) early_q++;
         if (cyc == inj_cyc) begin
            start = 1'b1;
            a     = inj_a;
         end else begin
            start = 1'b0;
         end
         next_cycle();
         cyc++;
      end
      start = 1'b0;
      if (busy) busy_cnt++;
      check($sformatf("latency a=%02h", op), cyc, 32'(op[6:4]) + 32'd2);
      check($sformatf("q a=%02h", op), {24'd0, q}, {24'd0, exp_q});
      check($sformatf("busy_cycles a=%02h", op), busy_cnt, 32'(op[6:4]) + 32'd2);
      check($sformatf("q_held_before_done a=%02h", op), early_q, 0);
      next_cycle();
      check($sformatf("done_pulse_width a=%02h", op), {31'd0, done}, 0);
      check($sformatf("busy_after_done a=%02h", op), {31'd0, busy}, 0);
      check($sformatf("q_held_after_done a=%02h", op), {24'd0, q}, {24'd0, exp_q});
   endtask

   initial begin
      int done_seen;

      // Reset, with start held high to show clr has priority.
      start = 1'b1;
      a     = 8'h7F;
      next_cycle();
      next_cycle();
      check("reset_q", {24'd0, q}, 0);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_done", {31'd0, done}, 0);
      start = 1'b0;
      clr   = 1'b0;
      next_cycle();

      // Directed cases.
      convert(8'h38, 0, 8'h00);   // +1.5   -> 1
      convert(8'h7F, 0, 8'h00);   // +31.0  -> 31
      convert(8'hC4, 0, 8'h00);   // -2.5   -> -2
      convert(8'h20, 0, 8'h00);   // +0.5   -> 0
      convert(8'h80, 0, 8'h00);   // -0.125 -> 0, not 8'h80
      check("neg_zero_q", {24'd0, q}, 0);

      // Stray start during SHIFT is ignored; the next IDLE start is honoured.
      convert(8'h7F, 3, 8'h38);
      convert(8'h38, 0, 8'h00);

      // Abort mid-SHIFT with clr after a nonzero result is on q.
      convert(8'hC4, 0, 8'h00);
      start = 1'b1;
      a     = 8'h7F;
      next_cycle();               // cycle 1
      start = 1'b0;
      next_cycle();               // cycle 2
      next_cycle();               // cycle 3
      next_cycle();               // cycle 4
      clr = 1'b1;
      next_cycle();               // cycle 5
      clr = 1'b0;
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_q", {24'd0, q}, 0);
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) done_seen++;
         next_cycle();
      end
      check("abort_no_done", done_seen, 0);
      convert(8'hC4, 0, 8'h00);

      // Random operands with random idle gaps between conversions.
      for (int n = 0; n < 300; n++) begin
         int gap;
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) next_cycle();
         convert(8'($urandom), 0, 8'h00);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/fp2int.md
# fp2int

Sequential converter from the lab's 8-bit floating-point format to an 8-bit two's-complement integer. It is the consumer at the result end of the FP adder: it turns a packed float result into an integer for display and checking. It uses the lab's controller/datapath split and one iterative shifter. Conversion latency is data-dependent, between 2 and 9 cycles.

## Interface
Parameters:
- None. The format is fixed.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- clr  in  1  reset; synchronous, active-high
- start  in  1  request a conversion; sampled only in IDLE
- a  in  8  packed float operand; sampled only on the accepting edge
- q  out  8  signed integer result, registered; held until the next conversion completes
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; q is valid and new in this cycle

## Operation
Float format:
- a[7] = sign, a[6:4] = exponent e (bias 3), a[3:0] = mantissa m.
- Hidden leading 1 is always present.
- value = (−1)^s × 1.mmmm × 2^(e−3).
- No zero, infinity or NaN encodings. The smallest magnitude is 0.125.

Conversion:
- Rounding is truncation toward zero.
- Magnitude = ({1,m} << e) >> 7. The range is 0..31, so the result never overflows.
- If e < 3, the magnitude is 0.
- A negative operand whose magnitude truncates to 0 gives q = 8'h00, never 8'h80 or −0.

Datapath:
- 12-bit shift register R.
- 3-bit down-counter CNT.
- Sign flop SG.
- Output register q.

State machine:
- IDLE: if start is high, load R = {7'b0,1,a[3:0]}, CNT = a[6:4], SG = a[7], then go to SHIFT. Otherwise stay.
- SHIFT: if CNT ≠ 0, set R <= R << 1 and CNT <= CNT − 1, and stay. If CNT = 0, set q <= SG ? −{3'b0,R[11:7]} : {3'b0,R[11:7]}, then go to DONE.
- DONE: done = 1, then go to IDLE unconditionally.

Rules:
- start in SHIFT or DONE is ignored. No queuing, and a is not sampled.
- start held high continuously restarts a conversion on each pass through IDLE. The cycle in which start is accepted is an IDLE cycle, so back-to-back conversions have 1 idle cycle between done and the next busy.
- q changes only on the edge that enters DONE, or on clr.

## Timing
Reset:
- clr high on an edge sets state = IDLE, q = 8'h00, busy = 0, done = 0, and clears R, CNT and SG.
- clr has priority over start and over any state, including mid-SHIFT. An aborted conversion produces no done pulse and leaves q = 0.

Cycle numbering: cycle 0 is the cycle in which start is high and the state is IDLE.
- Edge ending cycle 0: operand captured. busy = 1 from cycle 1.
- Cycles 1..e: one shift per cycle. With e = 0 there is no shift cycle.
- Edge ending cycle e+1: q written, state enters DONE.
- Cycle e+2: done = 1 and q valid, for exactly 1 cycle.
- Edge ending cycle e+2: return to IDLE. busy = 0 from cycle e+3.

Latency and throughput:
- start-to-done latency is e+2 cycles: minimum 2 (e=0), maximum 9 (e=7).
- busy is high for e+2 cycles per conversion.
- done and busy are both combinational decodes of the registered state, so they are glitch-free relative to clk.

## Test plan
- a=8'h38 (+1.5), start pulse in cycle 0: done in cycle 5, q=8'h01, busy high in cycles 1–5.
- a=8'h7F (+31.0): done in cycle 9, q=8'h1F. This checks the maximum magnitude and the 7-shift path.
- a=8'hC4 (−2.5): done in cycle 6, q=8'hFE. This checks truncation toward zero for negatives.
- a=8'h20 (+0.5) gives q=8'h00 with done in cycle 4. a=8'h80 (−0.125) gives q=8'h00, not 8'h80, with done in cycle 2.
- Convert 8'h7F. During cycle 3, drive start=1 with a=8'h38: this is ignored, and done in cycle 9 still shows q=8'h1F. Then a start accepted in the next IDLE cycle converts 8'h38 to q=8'h01.
- Start a conversion of 8'h7F and assert clr in cycle 4: from cycle 5, busy=0, q=8'h00, and no done pulse. A fresh start with a=8'hC4 then completes normally with q=8'hFE.
